// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side bus of the RAM port arbiter.
// Masters (processors or testbench) drive requests and consume read responses;
// the arbiter is the slave that grants and routes responses back.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one simple dual-port RAM (1 read + 1 write port,
// 1-cycle registered read) between NUM_REQ requesters. Independent round-robin
// for reads and writes, same-address read/write conflict resolution with a
// one-cycle read deferral limit, registered RAM commands, and a two-stage tag
// pipeline that steers read data back to the issuing requester.
module ram_port_arbiter #(
  parameter  int NUM_REQ         = 2,
  parameter  int DATA_SIZE_BYTES = 1,
  parameter  int ADDR_WIDTH      = 8,
  localparam int DATA_WIDTH      = DATA_SIZE_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     io_bus,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  input  logic                  i_ram_rd_valid
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Round-robin pointers and the conflict deferral flag
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic             r_rdDefer;

  // Read tag pipeline, aligned with the RAM's registered read
  logic             r_pend1;
  logic             r_pend2;
  logic [PTR_W-1:0] r_tag1;
  logic [PTR_W-1:0] r_tag2;

  // Combinational arbitration results
  logic [NUM_REQ-1:0]    w_rdCand;
  logic [NUM_REQ-1:0]    w_wrCand;
  logic [NUM_REQ-1:0]    w_rdOneHot;
  logic [NUM_REQ-1:0]    w_wrOneHot;
  logic                  w_rdFound;
  logic                  w_wrFound;
  logic [PTR_W-1:0]      w_rdIdx;
  logic [PTR_W-1:0]      w_wrIdx;
  logic [ADDR_WIDTH-1:0] w_rdAddr;
  logic [ADDR_WIDTH-1:0] w_wrAddr;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic                  w_conflict;
  logic                  w_rdGrant;
  logic                  w_wrGrant;

  // Round-robin pick: first candidate at or above ptr, else first overall (wrap)
  function automatic logic [NUM_REQ-1:0] rrOneHot(
    input logic [NUM_REQ-1:0] cand,
    input logic [PTR_W-1:0]   ptr
  );
    logic found;
    rrOneHot = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i] && (PTR_W'(i) >= ptr)) begin
        rrOneHot[i] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && cand[i]) begin
        rrOneHot[i] = 1'b1;
        found       = 1'b1;
      end
    end
  endfunction

  // Pointer advance: granted index + 1, wrapping at the last requester
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] idx);
    nextPtr = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
  endfunction

  // Find read and write winners and decode their index, address and data
  always_comb begin
    w_rdCand   = io_bus.req_valid & ~io_bus.req_we;
    w_wrCand   = io_bus.req_valid &  io_bus.req_we;
    w_rdOneHot = rrOneHot(w_rdCand, r_rdPtr);
    w_wrOneHot = rrOneHot(w_wrCand, r_wrPtr);
    w_rdFound  = |w_rdOneHot;
    w_wrFound  = |w_wrOneHot;
    w_rdIdx    = '0;
    w_wrIdx    = '0;
    w_rdAddr   = '0;
    w_wrAddr   = '0;
    w_wrData   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rdOneHot[i]) begin
        w_rdIdx  = PTR_W'(i);
        w_rdAddr = io_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (w_wrOneHot[i]) begin
        w_wrIdx  = PTR_W'(i);
        w_wrAddr = io_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wrData = io_bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Same-address conflict: write wins first, the deferred read wins next time
  always_comb begin
    w_conflict = w_rdFound && w_wrFound && (w_rdAddr == w_wrAddr);
    w_rdGrant  = w_rdFound && (!w_conflict ||  r_rdDefer);
    w_wrGrant  = w_wrFound && (!w_conflict || !r_rdDefer);
  end

  // Ready strobes to the winners; nothing is accepted while reset is held
  always_comb begin
    io_bus.req_ready = '0;
    if (!rst) begin
      io_bus.req_ready = (w_rdGrant ? w_rdOneHot : '0) |
                         (w_wrGrant ? w_wrOneHot : '0);
    end
  end

  // Pointer and deferral state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_rdDefer <= 1'b0;
    end else begin
      if (w_rdGrant) r_rdPtr <= nextPtr(w_rdIdx);
      if (w_wrGrant) r_wrPtr <= nextPtr(w_wrIdx);
      if (w_conflict && !r_rdDefer) r_rdDefer <= 1'b1;
      else if (w_rdGrant)           r_rdDefer <= 1'b0;
    end
  end

  // Registered RAM commands; address/data hold when no grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ram_rd_en   <= 1'b0;
      o_ram_rd_addr <= '0;
      o_ram_wr_en   <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
    end else begin
      o_ram_rd_en <= w_rdGrant;
      o_ram_wr_en <= w_wrGrant;
      if (w_rdGrant) o_ram_rd_addr <= w_rdAddr;
      if (w_wrGrant) begin
        o_ram_wr_addr <= w_wrAddr;
        o_ram_wr_data <= w_wrData;
      end
    end
  end

  // Two-stage tag pipeline matching command register plus RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
      r_tag1  <= '0;
      r_tag2  <= '0;
    end else begin
      r_pend1 <= w_rdGrant;
      if (w_rdGrant) r_tag1 <= w_rdIdx;
      r_pend2 <= r_pend1;
      r_tag2  <= r_tag1;
    end
  end

  // Steer the response strobe to the issuing requester; data is shared
  always_comb begin
    io_bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      io_bus.rsp_valid[i] = r_pend2 && (r_tag2 == PTR_W'(i));
    end
    io_bus.rsp_data = i_ram_rd_data;
  end

  // The RAM's read-valid must line up with the tag pipeline's last stage
  property p_rdValidAligned;
    @(posedge clk) disable iff (rst) (i_ram_rd_valid == r_pend2);
  endproperty
  a_rdValidAligned: assert property (p_rdValidAligned);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural
// simple dual-port RAM (1-cycle registered read) on the RAM side.
module tb_ram_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 8;
  localparam int DW      = 8;

  logic clk = 1'b0;
  logic rst;

  logic          ramRdEn;
  logic [AW-1:0] ramRdAddr;
  logic          ramWrEn;
  logic [AW-1:0] ramWrAddr;
  logic [DW-1:0] ramWrData;
  logic [DW-1:0] ramRdData;
  logic          ramRdValid;

  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  logic [1:0]    rrReady [4];
  logic [AW-1:0] rrAddr  [4];

  ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_port_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_SIZE_BYTES(1),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus),
    .o_ram_rd_en(ramRdEn),
    .o_ram_rd_addr(ramRdAddr),
    .o_ram_wr_en(ramWrEn),
    .o_ram_wr_addr(ramWrAddr),
    .o_ram_wr_data(ramWrData),
    .i_ram_rd_data(ramRdData),
    .i_ram_rd_valid(ramRdValid)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Behavioural RAM: write and registered read on the same edge
  always @(posedge clk) begin
    if (ramWrEn) mem[ramWrAddr] <= ramWrData;
    if (ramRdEn) ramRdData <= mem[ramRdAddr];
  end

  // RAM read-valid strobe, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) ramRdValid <= 1'b0;
    else     ramRdValid <= ramRdEn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: never both RAM enables at one address; read-valid matches response
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("noRdWrClash",
                  32'(ramRdEn && ramWrEn && (ramRdAddr == ramWrAddr)), 32'd0);
      checkOutput("rdValidVsRsp", 32'(ramRdValid), 32'(|bus.rsp_valid));
    end
  end

  initial begin
    rrReady = '{2'b01, 2'b10, 2'b01, 2'b10};
    rrAddr  = '{8'h01, 8'h02, 8'h01, 8'h02};

    // Reset state, with requests pending to show ready is held low
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    checkOutput("rstReady", 32'(bus.req_ready), 32'd0);
    checkOutput("rstRdEn", 32'(ramRdEn), 32'd0);
    checkOutput("rstWrEn", 32'(ramWrEn), 32'd0);
    checkOutput("rstRdAddr", 32'(ramRdAddr), 32'd0);
    checkOutput("rstWrAddr", 32'(ramWrAddr), 32'd0);
    checkOutput("rstWrData", 32'(ramWrData), 32'd0);
    checkOutput("rstRsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single read: req0 writes 0x10=0xA5, then req1 reads it back
    applyStimulus(2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
    #1 checkOutput("fillReady", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("fillWrEn", 32'(ramWrEn), 32'd1);
    checkOutput("fillWrAddr", 32'(ramWrAddr), 32'h10);
    checkOutput("fillWrData", 32'(ramWrData), 32'hA5);
    checkOutput("fillRdEn", 32'(ramRdEn), 32'd0);
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h00);
    #1 checkOutput("rdReady", 32'(bus.req_ready), 32'h2);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("rdEnT1", 32'(ramRdEn), 32'd1);
    checkOutput("rdAddrT1", 32'(ramRdAddr), 32'h10);
    checkOutput("rdWrEnT1", 32'(ramWrEn), 32'd0);
    checkOutput("rdRspT1", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("rdRspT2", 32'(bus.rsp_valid), 32'h2);
    checkOutput("rdDataT2", 32'(bus.rsp_data), 32'hA5);
    checkOutput("rdEnT2", 32'(ramRdEn), 32'd0);

    // Round-robin after reset: continuous reads from both, grants alternate
    rst = 1'b1;
    #2 rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1 checkOutput($sformatf("rrReady%0d", k), 32'(bus.req_ready), 32'(rrReady[k]));
      tick();
      checkOutput($sformatf("rrRdEn%0d", k), 32'(ramRdEn), 32'd1);
      checkOutput($sformatf("rrRdAddr%0d", k), 32'(ramRdAddr), 32'(rrAddr[k]));
      if (k > 0) begin
        checkOutput($sformatf("rrRsp%0d", k), 32'(bus.rsp_valid), 32'(rrReady[k-1]));
      end
    end
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("rrRspLast", 32'(bus.rsp_valid), 32'(rrReady[3]));

    // Parallel: write 0x20 from req0 and read 0x21 from req1 in one cycle
    applyStimulus(2'b11, 2'b01, 8'h20, 8'h21, 8'h3C, 8'h00);
    #1 checkOutput("parReady", 32'(bus.req_ready), 32'h3);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("parRdEn", 32'(ramRdEn), 32'd1);
    checkOutput("parRdAddr", 32'(ramRdAddr), 32'h21);
    checkOutput("parWrEn", 32'(ramWrEn), 32'd1);
    checkOutput("parWrAddr", 32'(ramWrAddr), 32'h20);
    checkOutput("parWrData", 32'(ramWrData), 32'h3C);

    // Conflict: req0 keeps writing 0x30=0x77 while req1 reads 0x30
    applyStimulus(2'b11, 2'b01, 8'h30, 8'h30, 8'h77, 8'h00);
    #1 checkOutput("cfReadyT0", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("cfWrEnT1", 32'(ramWrEn), 32'd1);
    checkOutput("cfWrAddrT1", 32'(ramWrAddr), 32'h30);
    checkOutput("cfRdEnT1", 32'(ramRdEn), 32'd0);
    #1 checkOutput("cfReadyT1", 32'(bus.req_ready), 32'h2);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("cfRdEnT2", 32'(ramRdEn), 32'd1);
    checkOutput("cfRdAddrT2", 32'(ramRdAddr), 32'h30);
    checkOutput("cfWrEnT2", 32'(ramWrEn), 32'd0);
    tick();
    checkOutput("cfRspT3", 32'(bus.rsp_valid), 32'h2);
    checkOutput("cfDataT3", 32'(bus.rsp_data), 32'h77);

    // Async reset one cycle after a read grant to req0
    applyStimulus(2'b01, 2'b00, 8'h44, 8'h00, 8'h00, 8'h00);
    #1 checkOutput("arReady", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("arRdEn", 32'(ramRdEn), 32'd1);
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkOutput("arRstRdEn", 32'(ramRdEn), 32'd0);
    checkOutput("arRstRdAddr", 32'(ramRdAddr), 32'd0);
    checkOutput("arRstWrAddr", 32'(ramWrAddr), 32'd0);
    checkOutput("arRstWrData", 32'(ramWrData), 32'd0);
    checkOutput("arRstRsp", 32'(bus.rsp_valid), 32'd0);
    checkOutput("arRstReady", 32'(bus.req_ready), 32'd0);
    tick();
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    checkOutput("arRspAfter1", 32'(bus.rsp_valid), 32'd0);
    tick();
    checkOutput("arRspAfter2", 32'(bus.rsp_valid), 32'd0);
    applyStimulus(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
    #1 checkOutput("arNextGrant", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("arNextRdAddr", 32'(ramRdAddr), 32'h01);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one simple dual-port simulation RAM (one read port, one write port, 1-cycle registered read) between NUM_REQ requesters. Each cycle it grants at most one read and at most one write, each by independent round-robin. It resolves the same-cycle read/write address conflict that the RAM forbids, and routes read data back to the requester that issued the read. It sits between processor-side or testbench masters and the RAM instance and registers all RAM command signals.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- DATA_SIZE_BYTES, 1: RAM word size in bytes; DATA_WIDTH = DATA_SIZE_BYTES*8 (localparam).
- ADDR_WIDTH, 8: RAM word-address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  request accepted this cycle (combinational).
- rsp_valid  out  NUM_REQ  one-hot read response strobe.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters; valid only with rsp_valid.
- ram_rd_en, ram_rd_addr  out  1, ADDR_WIDTH  registered RAM read command.
- ram_wr_en, ram_wr_addr, ram_wr_data  out  1, ADDR_WIDTH, DATA_WIDTH  registered RAM write command.
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- ram_rd_valid  in  1  RAM read-valid strobe.

## Operation
- Read candidates: req_valid & ~req_we. Write candidates: req_valid & req_we.
- Requester i transfers when req_valid[i] && req_ready[i]. The requester holds valid, we, addr and wdata stable until the transfer. A request is never withdrawn.
- Round-robin: rd_ptr_q and wr_ptr_q, each 0..NUM_REQ-1. The search starts at the pointer and wraps at NUM_REQ-1 to 0. On a grant, the pointer moves to granted index + 1 (mod NUM_REQ). With no grant, the pointer holds.
- Conflict: occurs when a read winner and a write winner both exist and have equal addresses.
  - If rd_defer_q = 0: the write is granted, the read is suppressed (no ready, rd_ptr_q holds), and rd_defer_q is set to 1.
  - If rd_defer_q = 1: the read is granted and the write is suppressed (wr_ptr_q holds).
  - rd_defer_q clears on any read grant.
  - This guarantees a read is deferred at most one cycle.
- A non-conflicting read and write are both granted in the same cycle.
- Command registers: on grant, load ram_*_en = 1 with the granted addr/wdata on the next edge. Otherwise en = 0, and addr/data hold their last value.
- Read tag pipeline:
  - tag1_q/pend1_q load alongside ram_rd_en.
  - tag2_q/pend2_q load from stage 1.
  - rsp_valid[i] = pend2_q && tag2_q == i.
  - rsp_data = ram_rd_data (combinational passthrough).
- Invariant checked in simulation: ram_rd_valid == pend2_q whenever rst is low.
- No response backpressure: requesters must accept rsp_valid when it occurs.

## Timing
- Accept in cycle T; RAM command visible in T+1; RAM samples at the end of T+1.
- Read data and rsp_valid appear in T+2. Read latency is 2 cycles from req_ready.
- Write accepted at T is committed in the RAM at the end of T+1.
- Ordering: a read accepted at T+1 or later to the same address returns the new data. A read accepted before a write returns the old data.
- Throughput: 1 read + 1 write per cycle, sustained.
- Reset values:
  - All ram_* outputs 0.
  - rsp_valid 0; req_ready 0 while rst is asserted.
  - rd_ptr_q, wr_ptr_q 0.
  - rd_defer_q, pend1_q, pend2_q, tag1_q, tag2_q 0.
- Reset mid-operation: in-flight reads are dropped with no rsp_valid. In-flight writes may or may not reach the RAM; the test does not depend on them.

## Test plan
- Single read: fill the RAM via requester 0 writes 0x10->0xA5. Requester 1 reads 0x10 at T -> req_ready[1] at T, ram_rd_en at T+1, rsp_valid = 2'b10 and rsp_data = 0xA5 at T+2.
- Round-robin: both requesters issue continuous reads of 0x01/0x02 after reset -> grants alternate 0,1,0,1. Exactly one read grant per cycle, with no starvation.
- Parallel: req0 writes 0x20 = 0x3C while req1 reads 0x21 in the same cycle -> both ready at T, ram_rd_en and ram_wr_en both set at T+1.
- Conflict:
  - req0 writes 0x30 = 0x77 repeatedly while req1 reads 0x30 -> write granted at T, read deferred, read granted at T+1 with the write suppressed.
  - rsp_data = 0x77 at T+3.
  - The RAM never sees rd_addr == wr_addr with both enables set.
- Async reset: assert rst one cycle after a read grant -> all outputs 0 immediately. No rsp_valid after deassert. The next grant goes to requester 0.
